// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-wide RAM port controller: request widths,
// FSM state encodings and the RAM byte type.
package mem_ctrl_pkg;

  typedef logic [1:0] mem_req_t;
  localparam mem_req_t MEM_REQ_NONE = 2'b00;
  localparam mem_req_t MEM_REQ_BYTE = 2'b01;
  localparam mem_req_t MEM_REQ_HALF = 2'b10;
  localparam mem_req_t MEM_REQ_WORD = 2'b11;

  typedef logic [7:0] ram_byte_t;

  typedef enum logic [1:0] {
    MEMCTRL_IDLE  = 2'd0,
    MEMCTRL_READ  = 2'd1,
    MEMCTRL_WRITE = 2'd2,
    MEMCTRL_DONE  = 2'd3
  } memctrl_state_e;

  // Number of byte beats for a request width.
  function automatic logic [2:0] req_bytes(input mem_req_t r);
    case (r)
      MEM_REQ_BYTE: req_bytes = 3'd1;
      MEM_REQ_HALF: req_bytes = 3'd2;
      default:      req_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM-stage requests onto one byte-wide synchronous RAM
// port, serializing each access into little-endian byte beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_data_o,
  output logic                  if_valid_o,
  input  logic [1:0]            mem_read_req_i,
  input  logic [1:0]            mem_write_req_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_valid_o,
  input  logic [7:0]            ram_din_i,
  output logic [7:0]            ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic                  ram_wr_o
);

  memctrl_state_e        state;
  logic [2:0]            cnt;
  logic [2:0]            nbytes;
  logic                  owner_if;
  logic [DATA_WIDTH-1:0] wbuf;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [1:0]            cap_idx;

  // Read data trails the address by one cycle, so beat cnt carries byte cnt-1.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    asm_next = asm_q;
    if (cnt != 3'd0) asm_next[{cap_idx, 3'b000} +: 8] = ram_din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MEMCTRL_IDLE;
      cnt         <= '0;
      nbytes      <= '0;
      owner_if    <= 1'b0;
      wbuf        <= '0;
      asm_q       <= '0;
      ram_a_o     <= '0;
      ram_dout_o  <= '0;
      ram_wr_o    <= 1'b0;
      if_data_o   <= '0;
      if_valid_o  <= 1'b0;
      mem_data_o  <= '0;
      mem_valid_o <= 1'b0;
    end else begin
      if_valid_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      case (state)
        MEMCTRL_IDLE: begin
          cnt   <= '0;
          asm_q <= '0;
          if (mem_write_req_i != MEM_REQ_NONE) begin
            state      <= MEMCTRL_WRITE;
            nbytes     <= req_bytes(mem_write_req_i);
            owner_if   <= 1'b0;
            ram_a_o    <= mem_addr_i;
            ram_wr_o   <= 1'b1;
            ram_dout_o <= mem_wdata_i[7:0];
            wbuf       <= mem_wdata_i >> 8;
          end else if (mem_read_req_i != MEM_REQ_NONE) begin
            state    <= MEMCTRL_READ;
            nbytes   <= req_bytes(mem_read_req_i);
            owner_if <= 1'b0;
            ram_a_o  <= mem_addr_i;
          end else if (if_req_i) begin
            state    <= MEMCTRL_READ;
            nbytes   <= 3'd4;
            owner_if <= 1'b1;
            ram_a_o  <= if_addr_i;
          end
        end
        MEMCTRL_READ: begin
          cnt <= cnt + 3'd1;
          if (cnt + 3'd1 < nbytes) ram_a_o <= ram_a_o + ADDR_WIDTH'(1);
          if (cnt != 3'd0) asm_q <= asm_next;
          if (cnt == nbytes) begin
            state <= MEMCTRL_DONE;
            if (owner_if) begin
              if_data_o  <= asm_next;
              if_valid_o <= 1'b1;
            end else begin
              mem_data_o  <= asm_next;
              mem_valid_o <= 1'b1;
            end
          end
        end
        MEMCTRL_WRITE: begin
          cnt <= cnt + 3'd1;
          if (cnt + 3'd1 < nbytes) begin
            ram_a_o    <= ram_a_o + ADDR_WIDTH'(1);
            ram_dout_o <= wbuf[7:0];
            wbuf       <= wbuf >> 8;
          end else begin
            ram_wr_o    <= 1'b0;
            state       <= MEMCTRL_DONE;
            mem_valid_o <= 1'b1;
          end
        end
        default: state <= MEMCTRL_IDLE;
      endcase
    end
  end

endmodule
